// File: rtl/piano_pkg.sv
// Shared note table and elaboration-time helpers for the polyphonic piano.
package piano_pkg;

  localparam int NOTE_CNT = 12;

  // Note frequencies in centi-hertz, index 0 = C4 .. 11 = B4.
  localparam int unsigned NOTE_HZ_X100 [0:NOTE_CNT-1] = '{
    26163, 27718, 29366, 31113, 32963, 34923,
    36999, 39200, 41530, 44000, 46616, 49388
  };

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Half-period in clock cycles for a note, shifted down by octave, never below 1.
  function automatic logic [63:0] half_period(input logic [3:0] idx,
                                              input logic [63:0] clk_hz,
                                              input logic [1:0] octave);
    logic [63:0] h;
    h = (clk_hz * 64'd50) / 64'(NOTE_HZ_X100[idx]);
    h = h >> octave;
    if (h == 64'd0) h = 64'd1;
    return h;
  endfunction

endpackage

// File: rtl/piano_voice.sv
// One square-wave voice: holds its key index, a half-period down-counter and the phase bit.
module piano_voice #(
  parameter int DIV_W = 20,
  parameter int KEY_W = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             alloc,
  input  logic             free,
  input  logic [DIV_W-1:0] half,
  input  logic [KEY_W-1:0] key_idx_in,
  output logic             ACTIVE,
  output logic             phase,
  output logic [KEY_W-1:0] key_idx
);

  logic             r_active;
  logic             r_phase;
  logic [DIV_W-1:0] r_cnt;
  logic [KEY_W-1:0] r_key;

  // Free beats everything; alloc starts at phase 0; otherwise count down and toggle at 1.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_active <= 1'b0;
      r_phase  <= 1'b0;
      r_cnt    <= '0;
      r_key    <= '0;
    end else if (free) begin
      r_active <= 1'b0;
      r_phase  <= 1'b0;
      r_cnt    <= '0;
    end else if (alloc) begin
      r_active <= 1'b1;
      r_phase  <= 1'b0;
      r_cnt    <= half;
      r_key    <= key_idx_in;
    end else if (r_active) begin
      if (r_cnt == DIV_W'(1)) begin
        r_phase <= ~r_phase;
        r_cnt   <= half;
      end else begin
        r_cnt <= r_cnt - DIV_W'(1);
      end
    end
  end

  assign ACTIVE  = r_active;
  assign phase   = r_phase;
  assign key_idx = r_key;

endmodule

// File: rtl/piano_poly.sv
// Polyphonic piano: key synchroniser, press/release edges, pending mask, voice allocator,
// release matcher, voice-count mixer and first-order sigma-delta audio bit.
module piano_poly import piano_pkg::*; #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int NUM_KEYS   = 12,
  parameter int NUM_VOICES = 4,
  parameter int DIV_W      = 20,
  localparam int KEY_W     = clog2(NUM_KEYS),
  localparam int MIX_W     = clog2(NUM_VOICES + 1)
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [NUM_KEYS-1:0]   KEY,
  input  logic [1:0]            OCTAVE,
  output logic                  FREQ,
  output logic [MIX_W-1:0]      MIX,
  output logic [NUM_VOICES-1:0] ACTIVE,
  output logic                  DROP
);

  localparam int ACC_W = MIX_W + 1;

  logic [NUM_KEYS-1:0]   r_key_s1, r_key_s2, r_key_d;
  logic [NUM_KEYS-1:0]   r_pending, r_dropped;
  logic                  r_drop;
  logic [MIX_W-1:0]      r_mix;
  logic [ACC_W-1:0]      r_acc;
  logic                  r_freq;

  logic [NUM_KEYS-1:0]   w_rise, w_fall, w_cand;
  logic [NUM_KEYS-1:0]   w_pending_nxt, w_dropped_nxt;
  logic                  w_drop_nxt;
  logic                  w_any_cand, w_any_free;
  logic [KEY_W-1:0]      w_alloc_key;
  logic [NUM_VOICES-1:0] w_alloc, w_free, w_phase;
  logic [KEY_W-1:0]      w_key_idx [NUM_VOICES];
  logic [DIV_W-1:0]      w_half    [NUM_VOICES];
  logic [DIV_W-1:0]      w_tab     [NUM_KEYS][4];
  logic [MIX_W-1:0]      w_mix_nxt;
  logic [ACC_W-1:0]      w_sum;

  // Half-period constants for every key and octave shift, folded at elaboration.
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_tab
    for (genvar o = 0; o < 4; o++) begin : g_oct
      assign w_tab[k][o] = DIV_W'(half_period(4'(k), 64'(CLK_HZ), 2'(o)));
    end
  end

  // Two-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_key_s1 <= '0;
      r_key_s2 <= '0;
      r_key_d  <= '0;
    end else begin
      r_key_s1 <= KEY;
      r_key_s2 <= r_key_s1;
      r_key_d  <= r_key_s2;
    end
  end

  assign w_rise = r_key_s2 & ~r_key_d;
  assign w_fall = ~r_key_s2 & r_key_d;
  // A key released this cycle must not be handed to a voice.
  assign w_cand = r_pending & ~w_fall;

  // Priority allocator, release matcher and pending/drop bookkeeping.
  always_comb begin
    w_any_cand  = 1'b0;
    w_alloc_key = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (w_cand[k]) begin
        w_any_cand  = 1'b1;
        w_alloc_key = KEY_W'(k);
      end
    end
    // Free voices are judged on registered ACTIVE, so a voice freed now is usable next cycle.
    w_any_free = 1'b0;
    w_alloc    = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!ACTIVE[v]) begin
        w_any_free = 1'b1;
        w_alloc    = '0;
        w_alloc[v] = w_any_cand;
      end
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_free[v] = ACTIVE[v] & w_fall[w_key_idx[v]];
      w_half[v] = w_tab[w_alloc[v] ? w_alloc_key : w_key_idx[v]][OCTAVE];
    end
    w_pending_nxt = (r_pending | w_rise) & ~w_fall;
    if (w_any_cand && w_any_free) w_pending_nxt[w_alloc_key] = 1'b0;
    // Every waiting key that finds no voice is marked, so DROP fires once per press.
    w_drop_nxt    = ~w_any_free & (|(w_cand & ~r_dropped));
    w_dropped_nxt = (r_dropped | ({NUM_KEYS{~w_any_free}} & w_cand)) & w_pending_nxt & ~w_rise;
  end

  // Pending mask, per-key drop marks and the DROP pulse.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pending <= '0;
      r_dropped <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_dropped <= w_dropped_nxt;
      r_drop    <= w_drop_nxt;
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    piano_voice #(
      .DIV_W (DIV_W),
      .KEY_W (KEY_W)
    ) u_voice (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .alloc      (w_alloc[v]),
      .free       (w_free[v]),
      .half       (w_half[v]),
      .key_idx_in (w_alloc_key),
      .ACTIVE     (ACTIVE[v]),
      .phase      (w_phase[v]),
      .key_idx    (w_key_idx[v])
    );
  end

  // Popcount of sounding voices whose phase is high.
  always_comb begin
    w_mix_nxt = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_mix_nxt = w_mix_nxt + MIX_W'(ACTIVE[v] & w_phase[v]);
    end
  end

  assign w_sum = r_acc + ACC_W'(r_mix);

  // Registered mixer and sigma-delta modulator; acc stays below NUM_VOICES.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mix  <= '0;
      r_acc  <= '0;
      r_freq <= 1'b0;
    end else begin
      r_mix <= w_mix_nxt;
      if (w_sum >= ACC_W'(NUM_VOICES)) begin
        r_freq <= 1'b1;
        r_acc  <= w_sum - ACC_W'(NUM_VOICES);
      end else begin
        r_freq <= 1'b0;
        r_acc  <= w_sum;
      end
    end
  end

  assign MIX  = r_mix;
  assign FREQ = r_freq;
  assign DROP = r_drop;

endmodule

// File: tb/tb_piano_poly.sv
// Bench for piano_poly: directed scenarios plus random key/octave traffic, all checked
// cycle by cycle against a behavioural model of the key, voice and mixer rules.
module tb_piano_poly;

  localparam int CLK_HZ = 100_000;
  localparam int NK     = 12;
  localparam int NV     = 4;
  localparam int DIV_W  = 20;
  localparam int W      = 9;  // {active[3:0], mix[2:0], freq, drop}

  localparam int unsigned NOTES [0:NK-1] = '{
    26163, 27718, 29366, 31113, 32963, 34923,
    36999, 39200, 41530, 44000, 46616, 49388
  };

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] key;
  logic [1:0]    octave;
  logic          freq;
  logic [2:0]    mix;
  logic [NV-1:0] active;
  logic          drop;

  piano_poly #(
    .CLK_HZ     (CLK_HZ),
    .NUM_KEYS   (NK),
    .NUM_VOICES (NV),
    .DIV_W      (DIV_W)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .KEY     (key),
    .OCTAVE  (octave),
    .FREQ    (freq),
    .MIX     (mix),
    .ACTIVE  (active),
    .DROP    (drop)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NK-1:0] hist[$];       // KEY samples, newest first
  bit            m_pend [NK];
  bit            m_drp  [NK];
  bit            m_act  [NV];
  bit            m_ph   [NV];
  int            m_key  [NV];
  int            m_cnt  [NV];
  int            m_mix, m_acc;
  bit            m_freq, m_drop;
  logic [W-1:0]  exp_q[$];

  function automatic int model_half(input int k, input int oct);
    longint h;
    h = (longint'(CLK_HZ) * 50) / longint'(NOTES[k]);
    h = h >>> oct;
    if (h == 0) h = 1;
    return int'(h);
  endfunction

  function automatic void model_reset();
    hist = '{12'h0, 12'h0, 12'h0};
    for (int k = 0; k < NK; k++) begin
      m_pend[k] = 0;
      m_drp[k]  = 0;
    end
    for (int v = 0; v < NV; v++) begin
      m_act[v] = 0;
      m_ph[v]  = 0;
      m_key[v] = 0;
      m_cnt[v] = 0;
    end
    m_mix = 0; m_acc = 0; m_freq = 0; m_drop = 0;
    exp_q.delete();
  endfunction

  // Advance the model by one clock edge with the inputs present at that edge.
  function automatic void model_step(input logic [NK-1:0] k_in, input int oct);
    bit rise [NK];
    bit fall [NK];
    bit cand [NK];
    logic [NK-1:0] lvl, prv;
    logic [NV-1:0] a;
    int ak, av, nmix, sum;
    bit nofree, new_drop, p;
    lvl = hist[1];
    prv = hist[2];
    ak = -1; av = -1; nofree = 1;
    for (int k = 0; k < NK; k++) begin
      rise[k] = lvl[k] && !prv[k];
      fall[k] = !lvl[k] && prv[k];
      cand[k] = m_pend[k] && !fall[k];
      if (cand[k] && ak < 0) ak = k;
    end
    for (int v = 0; v < NV; v++) begin
      if (!m_act[v]) begin
        nofree = 0;
        if (av < 0) av = v;
      end
    end
    new_drop = 0;
    if (nofree) for (int k = 0; k < NK; k++) if (cand[k] && !m_drp[k]) new_drop = 1;
    nmix = 0;
    for (int v = 0; v < NV; v++) if (m_act[v] && m_ph[v]) nmix++;
    sum = m_acc + m_mix;
    if (sum >= NV) begin m_freq = 1; m_acc = sum - NV; end
    else           begin m_freq = 0; m_acc = sum;      end
    m_mix  = nmix;
    m_drop = new_drop;
    for (int v = 0; v < NV; v++) begin
      if (m_act[v] && fall[m_key[v]]) begin
        m_act[v] = 0; m_ph[v] = 0; m_cnt[v] = 0;
      end else if (v == av && ak >= 0) begin
        m_act[v] = 1; m_key[v] = ak; m_ph[v] = 0; m_cnt[v] = model_half(ak, oct);
      end else if (m_act[v]) begin
        if (m_cnt[v] == 1) begin
          m_ph[v]  = !m_ph[v];
          m_cnt[v] = model_half(m_key[v], oct);
        end else begin
          m_cnt[v] = m_cnt[v] - 1;
        end
      end
    end
    for (int k = 0; k < NK; k++) begin
      p = (m_pend[k] || rise[k]) && !fall[k];
      if (k == ak && av >= 0) p = 0;
      m_drp[k]  = (m_drp[k] || (nofree && cand[k])) && p && !rise[k];
      m_pend[k] = p;
    end
    hist.push_front(k_in);
    void'(hist.pop_back());
    for (int v = 0; v < NV; v++) a[v] = m_act[v];
    exp_q.push_back({a, 3'(m_mix), m_freq, m_drop});
  endfunction

  // ---------------- driver ----------------
  int       cyc = 0;
  int       chg_q[$];
  logic [2:0] last_mix = 3'd0;

  task automatic tick();
    logic [W-1:0] e;
    @(posedge clk);
    model_step(key, int'(octave));
    @(negedge clk);
    cyc++;
    if (exp_q.size() == 0) begin
      check_val("exp_q_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val("active", 32'(active), 32'(e[8:5]));
      check_val("mix",    32'(mix),    32'(e[4:2]));
      check_val("freq",   32'(freq),   32'(e[1]));
      check_val("drop",   32'(drop),   32'(e[0]));
    end
    if (mix !== last_mix) begin
      chg_q.push_back(cyc);
      last_mix = mix;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int drops;
    int base;
    int n0;
    rst_n  = 1'b0;
    key    = '1;
    octave = 2'd0;
    model_reset();

    // Reset with every key held: outputs stay cleared.
    repeat (3) @(negedge clk);
    check_val("rst_active", 32'(active), 32'd0);
    check_val("rst_mix",    32'(mix),    32'd0);
    check_val("rst_freq",   32'(freq),   32'd0);
    check_val("rst_drop",   32'(drop),   32'd0);

    // Keys 0..3 held across release: four voices fill in order, no drop.
    key   = 12'h00F;
    rst_n = 1'b1;
    model_reset();
    drops = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      drops += int'(drop);
      if (i == 4) check_val("alloc_latency", 32'(active), 32'h1);
      if (i == 7) check_val("alloc_all4",    32'(active), 32'hF);
    end
    check_val("no_drop_4keys", 32'(drops), 32'd0);

    // A4 alone, octave 0 then 1.
    key = '0;
    repeat (10) tick();
    key[9] = 1'b1;
    chg_q.delete();
    repeat (400) tick();
    check_val("a4_edges", 32'(chg_q.size() >= 3), 32'd1);
    if (chg_q.size() >= 3) begin
      check_val("a4_period_0", 32'(chg_q[1] - chg_q[0]), 32'd113);
      check_val("a4_period_1", 32'(chg_q[2] - chg_q[1]), 32'd113);
    end
    base = chg_q.size();
    for (int i = 0; i < 200 && chg_q.size() == base; i++) tick();
    check_val("a4_wait_edge", 32'(chg_q.size() > base), 32'd1);
    n0     = cyc;
    octave = 2'd1;
    chg_q.delete();
    repeat (300) tick();
    check_val("oct_edges", 32'(chg_q.size() >= 3), 32'd1);
    if (chg_q.size() >= 3) begin
      check_val("oct_old_period", 32'(chg_q[0] - n0),        32'd113);
      check_val("oct_new_period", 32'(chg_q[1] - chg_q[0]), 32'd56);
      check_val("oct_new_again",  32'(chg_q[2] - chg_q[1]), 32'd56);
    end

    // Release A4: voice frees within 3 cycles, MIX clears one cycle later.
    key = '0;
    repeat (3) tick();
    check_val("rel_active", 32'(active), 32'd0);
    tick();
    check_val("rel_mix", 32'(mix), 32'd0);
    octave = 2'd0;

    // Five keys on four voices: one DROP, then key 4 takes voice 2 after key 2 lifts.
    repeat (5) tick();
    key   = 12'h01F;
    drops = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      drops += int'(drop);
      if (i == 4) check_val("five_first",   32'(active), 32'h1);
      if (i == 7) check_val("five_full",    32'(active), 32'hF);
      if (i == 8) check_val("five_drop_at", 32'(drop),   32'd1);
    end
    check_val("five_drop_once", 32'(drops), 32'd1);
    key[2] = 1'b0;
    repeat (3) tick();
    check_val("k2_freed", 32'(active), 32'hB);
    tick();
    check_val("k4_takes_v2", 32'(active), 32'hF);

    // Four tones sounding together.
    octave = 2'd3;
    repeat (600) tick();

    // Short asynchronous reset mid-tone.
    rst_n = 1'b0;
    #1;
    check_val("async_active", 32'(active), 32'd0);
    check_val("async_mix",    32'(mix),    32'd0);
    check_val("async_freq",   32'(freq),   32'd0);
    check_val("async_drop",   32'(drop),   32'd0);
    #2;
    rst_n = 1'b1;
    model_reset();
    repeat (4) tick();
    check_val("restart_alloc", 32'(active), 32'h1);
    repeat (300) tick();

    // Random key toggles and octave changes.
    for (int it = 0; it < 150; it++) begin
      int r;
      int idx;
      int n;
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        idx = int'($urandom_range(0, 6));
        key[idx] = ~key[idx];
      end else if (r < 8) begin
        idx = int'($urandom_range(0, NK - 1));
        key[idx] = ~key[idx];
      end else begin
        octave = 2'($urandom_range(0, 3));
      end
      n = int'($urandom_range(1, 60));
      repeat (n) tick();
    end
    key = '0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
